// File: rtl/blob_report_scheduler.sv
// Frame-level readout controller: snapshots the blob box table on end-of-frame and
// streams a header plus one record per live box over a valid/ready interface.
module blob_report_scheduler #(
  parameter int unsigned MAX_OBJ_NUM = 15,
  parameter int unsigned B_BITS      = 4,
  parameter int unsigned FID_W       = 16
) (
  input  logic                      app_clk,
  input  logic                      app_rst_n,
  input  logic                      enable,
  input  logic                      frame_done,
  input  logic [MAX_OBJ_NUM*44-1:0] boxes_in,
  input  logic [MAX_OBJ_NUM-1:0]    valid_mask_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sof,
  output logic                      out_eof,
  output logic [47:0]               out_data,
  output logic                      busy,
  output logic [FID_W-1:0]          frame_id,
  output logic [FID_W-1:0]          drop_count
);

  localparam int unsigned BOX_W  = 44;
  localparam int unsigned DATA_W = 48;
  localparam int unsigned PAD_W  = DATA_W - FID_W - B_BITS;

  typedef enum logic [1:0] {IDLE, HDR, BOX} state_t;

  state_t                       state;
  logic [MAX_OBJ_NUM*BOX_W-1:0] snap;
  logic [MAX_OBJ_NUM-1:0]       rem;
  logic [B_BITS-1:0]            cur_idx;

  logic [MAX_OBJ_NUM-1:0]       rem_clr;
  logic [B_BITS-1:0]            hdr_idx;
  logic [B_BITS-1:0]            nxt_idx;
  logic [DATA_W-1:0]            hdr_rec;
  logic [DATA_W-1:0]            nxt_rec;
  logic                         frame_evt;

  function automatic logic [B_BITS-1:0] lowest(input logic [MAX_OBJ_NUM-1:0] m);
    logic [B_BITS-1:0] r;
    r = '0;
    for (int i = int'(MAX_OBJ_NUM) - 1; i >= 0; i--) begin
      if (m[i]) r = B_BITS'(i);
    end
    return r;
  endfunction

  function automatic logic [B_BITS-1:0] popcnt(input logic [MAX_OBJ_NUM-1:0] m);
    logic [B_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MAX_OBJ_NUM); i++) begin
      r = r + B_BITS'(m[i]);
    end
    return r;
  endfunction

  function automatic logic single_bit(input logic [MAX_OBJ_NUM-1:0] m);
    return (m != '0) && ((m & (m - MAX_OBJ_NUM'(1))) == '0);
  endfunction

  // Candidate records for the first box (from HDR) and the box after the current one.
  always_comb begin
    rem_clr   = rem & ~(MAX_OBJ_NUM'(1) << cur_idx);
    hdr_idx   = lowest(rem);
    nxt_idx   = lowest(rem_clr);
    hdr_rec   = {4'(hdr_idx), snap[BOX_W*hdr_idx +: BOX_W]};
    nxt_rec   = {4'(nxt_idx), snap[BOX_W*nxt_idx +: BOX_W]};
    frame_evt = frame_done && enable;
  end

  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      rem        <= '0;
      cur_idx    <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      frame_id   <= '0;
      drop_count <= '0;
    end else begin
      // A frame arriving while a report drains only bumps the id and the drop counter.
      if (frame_evt && state != IDLE) begin
        frame_id <= frame_id + FID_W'(1);
        if (drop_count != '1) drop_count <= drop_count + FID_W'(1);
      end
      case (state)
        IDLE: begin
          if (frame_evt) begin
            snap      <= boxes_in;
            rem       <= valid_mask_in;
            frame_id  <= frame_id + FID_W'(1);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_sof   <= 1'b1;
            out_eof   <= (valid_mask_in == '0);
            out_data  <= {frame_id + FID_W'(1), PAD_W'(0), popcnt(valid_mask_in)};
            state     <= HDR;
          end
        end
        HDR: begin
          if (out_ready) begin
            out_sof <= 1'b0;
            if (rem == '0) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_eof   <= 1'b0;
              state     <= IDLE;
            end else begin
              cur_idx  <= hdr_idx;
              out_data <= hdr_rec;
              out_eof  <= single_bit(rem);
              state    <= BOX;
            end
          end
        end
        BOX: begin
          if (out_ready) begin
            rem <= rem_clr;
            if (rem_clr == '0) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_eof   <= 1'b0;
              state     <= IDLE;
            end else begin
              cur_idx  <= nxt_idx;
              out_data <= nxt_rec;
              out_eof  <= single_bit(rem_clr);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blob_report_scheduler.sv
// Randomised self-checking bench for blob_report_scheduler: a queue-based report model
// predicts every record, plus directed scenarios with literal expectations.
module tb_blob_report_scheduler;

  localparam int unsigned N = 15;

  logic            app_clk = 1'b0;
  logic            app_rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            frame_done = 1'b0;
  logic [N*44-1:0] boxes_in = '0;
  logic [N-1:0]    valid_mask_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_sof;
  logic            out_eof;
  logic [47:0]     out_data;
  logic            busy;
  logic [15:0]     frame_id;
  logic [15:0]     drop_count;

  blob_report_scheduler dut (
    .app_clk(app_clk), .app_rst_n(app_rst_n), .enable(enable), .frame_done(frame_done),
    .boxes_in(boxes_in), .valid_mask_in(valid_mask_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof), .out_data(out_data),
    .busy(busy), .frame_id(frame_id), .drop_count(drop_count)
  );

  always #5 app_clk = ~app_clk;

  typedef struct packed {
    logic [47:0] data;
    logic        sof;
    logic        eof;
  } rec_t;

  rec_t        q[$];
  logic [15:0] m_fid = '0;
  logic [15:0] m_drop = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a report is the list of records still owed downstream.
  always @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      q.delete();
      m_fid  = '0;
      m_drop = '0;
    end else begin
      automatic bit was_busy = (q.size() != 0);
      if (was_busy && out_ready) void'(q.pop_front());
      if (frame_done && enable) begin
        m_fid = m_fid + 16'd1;
        if (was_busy) begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else begin
          automatic int cnt = $countones(valid_mask_in);
          automatic int seen = 0;
          rec_t r;
          r.data = {m_fid, 28'd0, 4'(cnt)};
          r.sof  = 1'b1;
          r.eof  = (cnt == 0);
          q.push_back(r);
          for (int i = 0; i < int'(N); i++) begin
            if (valid_mask_in[i]) begin
              seen++;
              r.data = {4'(i), boxes_in[44*i +: 44]};
              r.sof  = 1'b0;
              r.eof  = (seen == cnt);
              q.push_back(r);
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge app_clk) begin
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("busy", 64'(busy), 64'(q.size() != 0));
    check("frame_id", 64'(frame_id), 64'(m_fid));
    check("drop_count", 64'(drop_count), 64'(m_drop));
    if (q.size() != 0) begin
      check("out_data", 64'(out_data), 64'(q[0].data));
      check("out_sof", 64'(out_sof), 64'(q[0].sof));
      check("out_eof", 64'(out_eof), 64'(q[0].eof));
    end
  end

  task automatic tick();
    @(negedge app_clk);
  endtask

  task automatic rand_boxes();
    for (int i = 0; i < int'(N); i++) boxes_in[44*i +: 44] = {12'($urandom), 32'($urandom)};
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    valid_mask_in = mask;
    rand_boxes();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    rand_boxes();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  logic [N*44-1:0] held;

  initial begin
    enable = 1'b1;
    repeat (3) tick();
    app_rst_n = 1'b1;
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_fid", 64'(frame_id), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);

    // Empty frame: lone header, sof and eof together.
    out_ready = 1'b1;
    pulse(15'h0);
    check("t1_hdr", 64'(out_data), 64'h0000_0001_0000_0000);
    check("t1_sofeof", 64'({out_sof, out_eof}), 64'b11);
    tick();
    check("t1_idle", 64'(busy), 64'd0);

    // Three boxes back to back.
    valid_mask_in = 15'h0025;
    rand_boxes();
    held = boxes_in;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("t2_hdr", 64'(out_data), 64'({16'd2, 28'd0, 4'd3}));
    tick();
    check("t2_idx0", 64'(out_data), 64'({4'd0, held[0 +: 44]}));
    tick();
    check("t2_idx2", 64'(out_data), 64'({4'd2, held[88 +: 44]}));
    check("t2_eof2", 64'(out_eof), 64'd0);
    tick();
    check("t2_idx5", 64'(out_data), 64'({4'd5, held[220 +: 44]}));
    check("t2_eof5", 64'(out_eof), 64'd1);
    tick();
    check("t2_busy", 64'(busy), 64'd0);

    // Same frame with ready toggling.
    pulse(15'h0025);
    for (int i = 0; i < 12; i++) begin
      out_ready = (i % 2 == 0);
      tick();
    end
    drain();

    // Frame arriving mid-report is dropped.
    out_ready = 1'b0;
    pulse(15'($urandom) | 15'h1);
    tick();
    pulse(15'($urandom));
    check("t4_drop", 64'(drop_count), 64'd1);
    check("t4_fid", 64'(frame_id), 64'd5);
    drain();
    out_ready = 1'b1;
    pulse(15'h0102);
    check("t4_hdr_fid", 64'(out_data[47:32]), 64'd6);
    drain();

    // Disabled: frame_done ignored.
    enable = 1'b0;
    repeat (3) begin pulse(15'h7FFF); tick(); end
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_fid", 64'(frame_id), 64'd6);
    enable = 1'b1;
    pulse(15'h4000);
    check("t5_hdr", 64'(out_data), 64'({16'd7, 28'd0, 4'd1}));
    drain();

    // Reset during BOX with ready low drops valid immediately.
    out_ready = 1'b0;
    pulse(15'h0003);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    #2 app_rst_n = 1'b0;
    #1 check("t6_valid", 64'(out_valid), 64'd0);
    tick();
    tick();
    app_rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    pulse(15'h0010);
    check("t6_fid", 64'(out_data[47:32]), 64'd1);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      enable        = ($urandom_range(0, 9) != 0);
      out_ready     = ($urandom_range(0, 9) < 7);
      frame_done    = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: valid_mask_in = '0;
        1: valid_mask_in = N'(1) << $urandom_range(0, N - 1);
        default: valid_mask_in = 15'($urandom);
      endcase
      rand_boxes();
      tick();
    end
    frame_done = 1'b0;
    enable = 1'b1;
    drain();

    // Saturate the drop counter.
    out_ready = 1'b0;
    pulse(15'h0001);
    frame_done = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    frame_done = 1'b0;
    check("t4_sat", 64'(drop_count), 64'hFFFF);
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
